// File: rtl/sa_feed_ctrl_if.sv
// Operand/control bundle between the operand source and sa_feed_ctrl.
// master: source side (start/k_len/in_*); slave: controller side (busy/in_ready/sa_*/done).
interface sa_feed_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int KW    = 16
);
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*HPE-1:0]   in_a;
    logic [WIDTH*VPE-1:0]   in_b;
    logic [WIDTH*HPE-1:0]   sa_a;
    logic [WIDTH*VPE-1:0]   sa_b;
    logic                   sa_clr;
    logic                   done;

    modport master (
        output start, k_len, in_valid, in_a, in_b,
        input  busy, in_ready, sa_a, sa_b, sa_clr, done
    );

    modport slave (
        input  start, k_len, in_valid, in_a, in_b,
        output busy, in_ready, sa_a, sa_b, sa_clr, done
    );
endinterface

// File: rtl/sa_feed_ctrl.sv
// Systolic-array feed sequencer: clear, skewed operand feed, zero drain, done.
// Ports: CLK, RST (async high), bus (slave: start/k_len/in_* in, busy/in_ready/sa_*/done out).
module sa_feed_ctrl #(
    parameter int WIDTH  = 32,
    parameter int HPE    = 4,
    parameter int VPE    = 4,
    parameter int KW     = 16,
    parameter int PE_LAT = 1
) (
    input  logic           CLK,
    input  logic           RST,
    sa_feed_ctrl_if.slave  bus
);
    localparam int D  = HPE + VPE - 2 + PE_LAT;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_q;
    logic [DW-1:0]   drn_q;
    logic            busy_q, rdy_q, clr_q, done_q;
    logic            accept;
    logic            last_beat;
    logic            drain_end;

    assign accept    = bus.in_valid & rdy_q;
    // Compare against k-1 so the counter never has to hold k itself.
    assign last_beat = accept && (beat_q == k_q - KW'(1));
    assign drain_end = (state_q == S_DRAIN) && (drn_q == DW'(D - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start)
                         state_d = (bus.k_len != '0) ? S_CLEAR : S_DONE;
            S_CLEAR: state_d = S_FEED;
            S_FEED:  if (last_beat) state_d = S_DRAIN;
            S_DRAIN: if (drain_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            rdy_q   <= (state_d == S_FEED);
            clr_q   <= (state_d == S_CLEAR);
            done_q  <= (state_d == S_DONE);
            if (state_q == S_IDLE && bus.start)
                k_q <= bus.k_len;
            if (accept)
                beat_q <= last_beat ? '0 : beat_q + KW'(1);
            if (state_q == S_DRAIN)
                drn_q <= drain_end ? '0 : drn_q + DW'(1);
        end
    end

    // Lane i is a shift line of i+1 registers; the last stage drives the array.
    // Every cycle shifts, injecting zero unless a beat is accepted.
    for (genvar i = 0; i < HPE; i++) begin : g_a
        logic [WIDTH-1:0] line_q [0:i];
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int s = 0; s <= i; s++) line_q[s] <= '0;
            end else begin
                line_q[0] <= accept ? bus.in_a[i*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= i; s++) line_q[s] <= line_q[s-1];
            end
        end
        assign bus.sa_a[i*WIDTH +: WIDTH] = line_q[i];
    end

    for (genvar j = 0; j < VPE; j++) begin : g_b
        logic [WIDTH-1:0] line_q [0:j];
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int s = 0; s <= j; s++) line_q[s] <= '0;
            end else begin
                line_q[0] <= accept ? bus.in_b[j*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= j; s++) line_q[s] <= line_q[s-1];
            end
        end
        assign bus.sa_b[j*WIDTH +: WIDTH] = line_q[j];
    end

    assign bus.busy     = busy_q;
    assign bus.in_ready = rdy_q;
    assign bus.sa_clr   = clr_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Directed bench for sa_feed_ctrl: cycle table plus hand sequences.
// Drives at posedge+1, samples at negedge.
module tb_sa_feed_ctrl;
    localparam int WIDTH  = 32;
    localparam int HPE    = 4;
    localparam int VPE    = 4;
    localparam int KW     = 16;
    localparam int PE_LAT = 1;
    localparam int D      = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sa_feed_ctrl_if #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE), .KW(KW)) bus ();

    sa_feed_ctrl #(
        .WIDTH(WIDTH), .HPE(HPE), .VPE(VPE), .KW(KW), .PE_LAT(PE_LAT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic [15:0]  k;
        logic         vld;
        logic [127:0] a;
        logic [127:0] b;
        logic         busy;
        logic         rdy;
        logic         clr;
        logic         done;
        logic [127:0] sa;
        logic [127:0] sb;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] ln(input int i, input logic [31:0] v);
        logic [127:0] r;
        r = '0;
        r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [31:0] alane(input int c, input int i);
        return {4'hA, 20'(c), 8'(i + 1)};
    endfunction

    function automatic logic [31:0] blane(input int c, input int i);
        return {4'hB, 20'(c), 8'(i + 1)};
    endfunction

    function automatic vec_t mk(input logic st, input int k, input logic bsy,
                                input logic rdy, input logic clr,
                                input logic dn, input logic [127:0] sa,
                                input logic [127:0] sb);
        vec_t v;
        v.start = st;
        v.k     = 16'(k);
        v.vld   = 1'b1;
        v.a     = {32'd4, 32'd3, 32'd2, 32'd1};
        v.b     = {32'd8, 32'd7, 32'd6, 32'd5};
        v.busy  = bsy;
        v.rdy   = rdy;
        v.clr   = clr;
        v.done  = dn;
        v.sa    = sa;
        v.sb    = sb;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdy"}, bus.in_ready, 0);
        chk({tag, "_clr"}, bus.sa_clr, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_sa"}, bus.sa_a, 0);
        chk({tag, "_sb"}, bus.sa_b, 0);
    endtask

    // Job with bench-side expectations: accept cycles are derived from vmask
    // (bit n = in_valid in cycle 2+n), lane i shows the beat accepted 1+i
    // cycles earlier. st2 = cycle of a second start pulse (k=5), abort_c =
    // cycle at which RST is raised mid-cycle.
    task automatic run_job(input string tag, input int k,
                           input logic [31:0] vmask, input int st2,
                           input int abort_c, input int ncyc);
        logic         acc_map [64];
        int           acc_n, c, last, done_c, dcount, src;
        logic [127:0] ea, eb, fa, fb;
        for (int n = 0; n < 64; n++) acc_map[n] = 1'b0;
        c = 2; acc_n = 0; last = 0;
        while (acc_n < k && c < 64) begin
            if (c - 2 >= 32 || vmask[c-2]) begin
                acc_map[c] = 1'b1;
                acc_n++;
                last = c;
            end
            c++;
        end
        done_c = last + D + 1;
        dcount = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            bus.start    = (cyc == 0) || (cyc == st2);
            bus.k_len    = (cyc == 0) ? 16'(k) : 16'd5;
            bus.in_valid = (cyc < 2 || cyc - 2 >= 32) ? 1'b1 : vmask[cyc-2];
            for (int i = 0; i < 4; i++) begin
                fa[i*32 +: 32] = alane(cyc, i);
                fb[i*32 +: 32] = blane(cyc, i);
            end
            bus.in_a = fa;
            bus.in_b = fb;
            @(negedge clk);
            ea = '0;
            eb = '0;
            for (int i = 0; i < 4; i++) begin
                src = cyc - 1 - i;
                if (src >= 0 && acc_map[src]) begin
                    ea[i*32 +: 32] = alane(src, i);
                    eb[i*32 +: 32] = blane(src, i);
                end
            end
            chk({tag, "_busy"}, bus.busy, (cyc >= 1 && cyc <= done_c));
            chk({tag, "_rdy"}, bus.in_ready, (cyc >= 2 && cyc <= last));
            chk({tag, "_clr"}, bus.sa_clr, (cyc == 1));
            chk({tag, "_done"}, bus.done, (cyc == done_c));
            chk({tag, "_sa"}, bus.sa_a, ea);
            chk({tag, "_sb"}, bus.sa_b, eb);
            if (bus.done === 1'b1) dcount++;
            if (cyc == abort_c) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, "_abort_sa"}, bus.sa_a, 0);
                chk({tag, "_abort_sb"}, bus.sa_b, 0);
                chk({tag, "_abort_busy"}, bus.busy, 0);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_count"}, 32'(dcount), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held with active-looking inputs.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.k_len = 16'd5;
        bus.in_valid = 1'b1;
        bus.in_a = {4{32'h1234_5678}};
        bus.in_b = {4{32'h9ABC_DEF0}};
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk_zero("rst_hold");
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk_zero("rst_rel");
            @(posedge clk);
            #1;
        end

        // Single beat k=1, then zero-length job.
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0, ln(0, 1), ln(0, 5));
        tbl[4]  = mk(0, 1, 1, 0, 0, 0, ln(1, 2), ln(1, 6));
        tbl[5]  = mk(0, 1, 1, 0, 0, 0, ln(2, 3), ln(2, 7));
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, ln(3, 4), ln(3, 8));
        tbl[7]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 15; r++) begin
            bus.start    = tbl[r].start;
            bus.k_len    = tbl[r].k;
            bus.in_valid = tbl[r].vld;
            bus.in_a     = tbl[r].a;
            bus.in_b     = tbl[r].b;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", r), bus.busy, tbl[r].busy);
            chk($sformatf("tbl%0d_rdy", r), bus.in_ready, tbl[r].rdy);
            chk($sformatf("tbl%0d_clr", r), bus.sa_clr, tbl[r].clr);
            chk($sformatf("tbl%0d_done", r), bus.done, tbl[r].done);
            chk($sformatf("tbl%0d_sa", r), bus.sa_a, tbl[r].sa);
            chk($sformatf("tbl%0d_sb", r), bus.sa_b, tbl[r].sb);
            @(posedge clk);
            #1;
        end

        // Back-pressure: valid 1,0,1,0,1 during FEED, k=3.
        run_job("bp", 3, 32'hFFFF_FFF5, -1, -1, 17);
        // Start pulse during FEED must be ignored.
        run_job("sbusy", 4, 32'hFFFF_FFFF, 3, -1, 18);
        // Abort in DRAIN of a k=8 job (DRAIN spans cycles 10..16).
        run_job("abort", 8, 32'hFFFF_FFFF, -1, 12, 20);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk_zero("post_abort");
            @(posedge clk);
            #1;
        end
        run_job("k2", 2, 32'hFFFF_FFFF, -1, -1, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
